// File: rtl/uart_rx_pkg.sv
// Shared definitions for the serial receiver: state encodings, oversampling
// constants and the default frame shape (also used by the transmitter).
package uart_rx_pkg;

  localparam int unsigned OSR         = 16;
  localparam int unsigned MID         = 7;
  localparam int unsigned DW          = 8;
  localparam int unsigned DBIT_DEF    = 8;
  localparam int unsigned SB_TICK_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BRK   = 3'd4
  } state_e;

  // Tick counter must reach SB_TICK-1, which needs a fifth bit past one bit time.
  function automatic int unsigned s_width(input int unsigned sb_tick);
    return (sb_tick > OSR) ? 5 : 4;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous pin; the reset value is chosen
// per pin so the line reads as its idle level straight out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled asynchronous serial receiver: false-start rejection,
// mid-cell sampling, framing-error flag and break-line lockout.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DBIT    = DBIT_DEF,
  parameter int unsigned SB_TICK = SB_TICK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err
);

  localparam int unsigned SW = s_width(SB_TICK);

  logic          rx_s;
  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    n_q, n_d;
  logic [7:0]    b_q, b_d;
  logic [7:0]    dout_d;
  logic          done_d;
  logic          ferr_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      dout         <= dout_d;
      rx_done_tick <= done_d;
      frame_err    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout;
    ferr_d  = frame_err;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end

      // Re-check the line at mid start bit; a short glitch drops back to idle.
      ST_START: begin
        if (s_tick) begin
          if (s_q == SW'(MID)) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s_q == SW'(OSR - 1)) begin
            b_d = {rx_s, b_q[7:1]};
            s_d = '0;
            if (n_q == 3'(DBIT - 1)) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      // Frame completes here; a low stop bit parks in brk until the line recovers.
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            dout_d  = b_q >> (DW - DBIT);
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            s_d     = '0;
            state_d = rx_s ? ST_IDLE : ST_BRK;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      ST_BRK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
